// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
// Holds the fetch FSM state enum, the NOP encoding and reset/step defaults.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam int unsigned DEF_RESET_PC = 32'd0;
  localparam int unsigned DEF_PC_STEP  = 32'd4;

endpackage

// File: rtl/fetch_out_buf.sv
// fetch_out_buf: output register feeding IF/ID plus a one-entry skid.
// Ports: clk, rst_n (sync, active-low); flush_i/load_i/push_i/pop_i/
// consume_i controls; inst_i/pc_i data in; valid_o/inst_o/pc_o output
// register; skid_valid_o skid occupancy.
module fetch_out_buf
  import fetch_pkg::*;
#(
  parameter int PC_W   = 64,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              consume_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic [PC_W-1:0]   pc_i,
  output logic              valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [PC_W-1:0]   pc_o,
  output logic              skid_valid_o
);

  localparam logic [INST_W-1:0] NOP = INST_W'(NOP_INST);

  logic              ov_q, ov_d;
  logic [INST_W-1:0] oi_q, oi_d;
  logic [PC_W-1:0]   op_q, op_d;
  logic              sv_q, sv_d;
  logic [INST_W-1:0] si_q, si_d;
  logic [PC_W-1:0]   sp_q, sp_d;

  // Later assignments win: flush beats everything, a refill beats
  // the plain consume that empties the register.
  always_comb begin
    ov_d = ov_q;
    oi_d = oi_q;
    op_d = op_q;
    sv_d = sv_q;
    si_d = si_q;
    sp_d = sp_q;
    if (consume_i) begin
      ov_d = 1'b0;
      oi_d = NOP;
      op_d = '0;
    end
    if (load_i) begin
      ov_d = 1'b1;
      oi_d = inst_i;
      op_d = pc_i;
    end
    if (pop_i) begin
      ov_d = 1'b1;
      oi_d = si_q;
      op_d = sp_q;
      sv_d = 1'b0;
    end
    if (push_i) begin
      sv_d = 1'b1;
      si_d = inst_i;
      sp_d = pc_i;
    end
    if (flush_i) begin
      ov_d = 1'b0;
      oi_d = NOP;
      op_d = '0;
      sv_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ov_q <= 1'b0;
      oi_q <= NOP;
      op_q <= '0;
      sv_q <= 1'b0;
      si_q <= NOP;
      sp_q <= '0;
    end else begin
      ov_q <= ov_d;
      oi_q <= oi_d;
      op_q <= op_d;
      sv_q <= sv_d;
      si_q <= si_d;
      sp_q <= sp_d;
    end
  end

  assign valid_o      = ov_q;
  assign inst_o       = oi_q;
  assign pc_o         = op_q;
  assign skid_valid_o = sv_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: IF stage; owns the PC, single-outstanding imem fetch,
// feeds IF/ID. Ports: clk, arst_n (sync active-low); imem_req_* / imem_rsp_*
// memory handshake; redirect_valid/redirect_pc from EX/MEM; stall from
// hazard unit; if_valid/if_inst/if_pc to IF/ID; misalign_err sticky flag.
// Optional: FETCH_MISALIGN_CHK_EN enables misaligned-redirect checking.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC),
  parameter logic [PC_W-1:0] PC_STEP  = PC_W'(DEF_PC_STEP)
) (
  input  logic              clk,
  input  logic              arst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              stall,
  output logic              if_valid,
  output logic [INST_W-1:0] if_inst,
  output logic [PC_W-1:0]   if_pc,
  output logic              misalign_err
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] redir_tgt;

  logic buf_flush;
  logic buf_load;
  logic buf_push;
  logic buf_pop;
  logic consume;
  logic out_free;
  logic skid_valid;

  assign consume  = if_valid & ~stall;
  assign out_free = ~if_valid | ~stall;

`ifdef FETCH_MISALIGN_CHK_EN
  logic mis_q, mis_d;

  assign redir_tgt = {redirect_pc[PC_W-1:2], 2'b00};

  always_comb begin
    mis_d = mis_q;
    if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      mis_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end

  assign misalign_err = mis_q;
`else
  assign redir_tgt    = redirect_pc;
  assign misalign_err = 1'b0;
`endif

  // Request only when the output can take the result without stalling
  // the pipe; held low during reset and on a redirect cycle.
  assign imem_req_valid = arst_n
                        & (state_q == ST_REQ)
                        & ~redirect_valid
                        & out_free;
  assign imem_req_addr  = pc_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_flush = 1'b0;
    buf_load  = 1'b0;
    buf_push  = 1'b0;
    buf_pop   = 1'b0;
    unique case (state_q)
      ST_REQ: begin
        if (imem_req_valid && imem_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          pc_d = pc_q + PC_STEP;
          if (out_free) begin
            buf_load = 1'b1;
            state_d  = ST_REQ;
          end else begin
            buf_push = 1'b1;
            state_d  = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (consume && skid_valid) begin
          buf_pop = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_DROP: begin
        if (imem_rsp_valid) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
    // Redirect overrides everything. An in-flight response that has
    // not yet returned must be swallowed in DROP before re-requesting.
    if (redirect_valid) begin
      pc_d      = redir_tgt;
      buf_flush = 1'b1;
      buf_load  = 1'b0;
      buf_push  = 1'b0;
      buf_pop   = 1'b0;
      if ((state_q == ST_WAIT) || (state_q == ST_DROP)) begin
        state_d = imem_rsp_valid ? ST_REQ : ST_DROP;
      end else begin
        state_d = ST_REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_out_buf #(
    .PC_W   (PC_W),
    .INST_W (INST_W)
  ) u_out_buf (
    .clk          (clk),
    .rst_n        (arst_n),
    .flush_i      (buf_flush),
    .load_i       (buf_load),
    .push_i       (buf_push),
    .pop_i        (buf_pop),
    .consume_i    (consume),
    .inst_i       (imem_rsp_data),
    .pc_i         (pc_q),
    .valid_o      (if_valid),
    .inst_o       (if_inst),
    .pc_o         (if_pc),
    .skid_valid_o (skid_valid)
  );

endmodule
